semaforo_monitor: RTL

Passive checker on the receiving end of the lamp interface driven by the traffic-light controller. It samples the one-hot lamp codes of both signals A and B and decodes each into a phase. It checks code legality, phase sequence and per-phase dwell time, and reports errors, current phases and the number of completed A cycles. It sits beside the controller in the top level and in the bench, and never drives the lamps.

---
 rtl/semaforo_monitor.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/semaforo_monitor.sv
// Passive checker for the A/B lamp interface: decodes phases, checks legality, order and dwell.
// Define SEMAFORO_MON_CYCLE_COUNT_EN to build the ciclos_a counter; otherwise it is tied to 0.
module semaforo_monitor #(
    parameter int unsigned T_VERDE    = 10,
    parameter int unsigned T_AMARELO  = 3,
    parameter int unsigned T_VERMELHO = 8,
    parameter int unsigned TOL        = 1,
    parameter int unsigned CNT_W      = 9,
    parameter bit          CHK_LONG_B = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] A,
    input  logic [2:0] B,
    input  logic       err_clr,
    output logic [1:0] phase_a,
    output logic [1:0] phase_b,
    output logic       err_valid,
    output logic       err_chan,
    output logic [2:0] err_code,
    output logic       err_sticky,
    output logic [7:0] ciclos_a,
    output logic       sync_ab
);

    typedef enum logic [1:0] {
        StVerde    = 2'd0,
        StAmarelo  = 2'd1,
        StVermelho = 2'd2,
        StUnk      = 2'd3
    } phase_t;

    typedef struct packed {
        phase_t           st;
        logic [CNT_W-1:0] dwell;
        logic             partial;
        logic             long_done;
    } trk_t;

    localparam logic [2:0] ENone     = 3'd0;
    localparam logic [2:0] EBadCode  = 3'd1;
    localparam logic [2:0] EBadTrans = 3'd2;
    localparam logic [2:0] EShort    = 3'd3;
    localparam logic [2:0] ELong     = 3'd4;

    localparam trk_t TrkRst = '{st: StUnk, dwell: '0, partial: 1'b1, long_done: 1'b0};

    function automatic phase_t decode(input logic [2:0] code);
        unique case (code)
            3'b100:  decode = StVerde;
            3'b010:  decode = StAmarelo;
            3'b001:  decode = StVermelho;
            default: decode = StUnk;
        endcase
    endfunction

    function automatic phase_t next_of(input phase_t ph);
        case (ph)
            StVerde:    next_of = StAmarelo;
            StAmarelo:  next_of = StVermelho;
            StVermelho: next_of = StVerde;
            default:    next_of = StUnk;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] t_min(input phase_t ph);
        case (ph)
            StVerde:   t_min = CNT_W'(T_VERDE);
            StAmarelo: t_min = CNT_W'(T_AMARELO);
            default:   t_min = CNT_W'(T_VERMELHO);
        endcase
    endfunction

    function automatic trk_t trk_next(input trk_t cur, input logic [2:0] code,
                                      input logic long_en, output logic [2:0] ecode);
        phase_t ph;
        trk_t   nxt;
        ph    = decode(code);
        nxt   = cur;
        ecode = ENone;
        if (ph == StUnk) begin
            // Only the entry into UNK is reported; a held illegal code stays quiet
            if (cur.st != StUnk) ecode = EBadCode;
            nxt = TrkRst;
        end else if (cur.st == StUnk) begin
            nxt = '{st: ph, dwell: CNT_W'(1), partial: 1'b1, long_done: 1'b0};
        end else if (ph == cur.st) begin
            if (cur.dwell != '1) nxt.dwell = cur.dwell + 1'b1;
            if (!cur.partial && !cur.long_done && long_en &&
                nxt.dwell >= t_min(cur.st) + CNT_W'(TOL + 1)) begin
                ecode         = ELong;
                nxt.long_done = 1'b1;
            end
        end else begin
            if (ph == next_of(cur.st)) begin
                if (!cur.partial && cur.dwell < t_min(cur.st)) ecode = EShort;
                nxt.partial = 1'b0;
            end else begin
                ecode       = EBadTrans;
                nxt.partial = 1'b1;
            end
            nxt.st        = ph;
            nxt.dwell     = CNT_W'(1);
            nxt.long_done = 1'b0;
        end
        return nxt;
    endfunction

    trk_t       trk_a_q, trk_a_d, trk_b_q, trk_b_d;
    logic [2:0] ecode_a, ecode_b, err_sel;
    logic       err_hit, long_en_b;
    logic       err_valid_q, err_chan_q, err_sticky_q;
    logic [2:0] err_code_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trk_a_q <= TrkRst;
            trk_b_q <= TrkRst;
        end else begin
            trk_a_q <= trk_a_d;
            trk_b_q <= trk_b_d;
        end
    end

    always_comb begin
        long_en_b = CHK_LONG_B || (trk_b_q.st != StVerde);
        trk_a_d   = trk_next(trk_a_q, A, 1'b1, ecode_a);
        trk_b_d   = trk_next(trk_b_q, B, long_en_b, ecode_b);
        err_hit   = (ecode_a != ENone) || (ecode_b != ENone);
        err_sel   = (ecode_a != ENone) ? ecode_a : ecode_b;
    end

    // An error arriving with err_clr wins and becomes the newly latched first error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_valid_q  <= 1'b0;
            err_chan_q   <= 1'b0;
            err_code_q   <= ENone;
            err_sticky_q <= 1'b0;
        end else begin
            err_valid_q <= err_hit;
            if (err_hit) err_chan_q <= (ecode_a == ENone);
            if (err_hit && (!err_sticky_q || err_clr)) begin
                err_code_q   <= err_sel;
                err_sticky_q <= 1'b1;
            end else if (err_clr) begin
                err_code_q   <= ENone;
                err_sticky_q <= 1'b0;
            end
        end
    end

`ifdef SEMAFORO_MON_CYCLE_COUNT_EN
    logic [7:0] ciclos_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ciclos_q <= 8'd0;
        end else if (trk_a_q.st == StVermelho && trk_a_d.st == StVerde) begin
            ciclos_q <= ciclos_q + 8'd1;
        end
    end
    assign ciclos_a = ciclos_q;
`else
    assign ciclos_a = 8'd0;
`endif

    always_comb begin
        phase_a    = trk_a_q.st;
        phase_b    = trk_b_q.st;
        sync_ab    = (trk_a_q.st == trk_b_q.st) && (trk_a_q.st != StUnk);
        err_valid  = err_valid_q;
        err_chan   = err_chan_q;
        err_code   = err_code_q;
        err_sticky = err_sticky_q;
    end

endmodule
